hif_queue_sequencer: RTL and testbench

//  Controller for the 1536x16 high-frequency circular sample queue (dual-port RAM).

---
 rtl/hif_q_pkg.sv | 30 +++
 rtl/circ_ptr.sv | 25 ++
 rtl/hif_queue_sequencer.sv | 133 +++++++++++++
 tb/tb_hif_queue_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hif_q_pkg.sv
// Shared defaults, state type and modulo-DEPTH pointer helpers for the
// high-frequency sample queue.
package hif_q_pkg;

    localparam int unsigned Q_DEPTH  = 1536;
    localparam int unsigned Q_AW     = 11;
    localparam int unsigned Q_TAPS   = 1021;
    localparam int unsigned Q_RD_LAT = 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        IDLE  = 2'd1,
        BURST = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic logic [Q_AW-1:0] ptr_inc(input logic [Q_AW-1:0] p);
        return (p == Q_AW'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [Q_AW-1:0] ptr_sub(input logic [Q_AW-1:0] p,
                                                 input logic [Q_AW-1:0] n);
        logic [Q_AW:0] pe;
        logic [Q_AW:0] ne;
        pe = {1'b0, p};
        ne = {1'b0, n};
        return (pe >= ne) ? Q_AW'(pe - ne) : Q_AW'(pe + (Q_AW+1)'(Q_DEPTH) - ne);
    endfunction

endpackage

// File: rtl/circ_ptr.sv
// Loadable pointer that wraps DEPTH-1 -> 0; load has priority over inc.
module circ_ptr #(
    parameter int unsigned AW    = 11,
    parameter int unsigned DEPTH = 1536
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (load)
            ptr <= load_val;
        else if (inc)
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/hif_queue_sequencer.sv
// Circular sample queue controller: owns write/read pointers and sequences a
// TAPS-long read burst of the newest samples after every triggering write.
module hif_queue_sequencer
    import hif_q_pkg::*;
#(
    parameter int unsigned DEPTH  = Q_DEPTH,
    parameter int unsigned AW     = Q_AW,
    parameter int unsigned TAPS   = Q_TAPS,
    parameter int unsigned RD_LAT = Q_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrt_smpl,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          rd_en,
    output logic          smpl_vld,
    output logic          first_smpl,
    output logic          last_smpl,
    output logic          sequencing,
    output logic          full,
    output logic          overrun
);

    localparam logic [AW:0]   TAPS_X  = (AW+1)'(TAPS);
    localparam logic [AW:0]   SPAN    = (AW+1)'(TAPS - 1);
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_RD = AW'(TAPS - 1);
    localparam logic [AW-1:0] LAST_DR = AW'(RD_LAT - 1);

    state_t            state, state_nx;
    logic [AW:0]       cnt;
    logic              pending;
    logic [AW-1:0]     new_ptr, rd_ptr, last_w, beat, w_sel, oldest;
    logic [AW:0]       w_ext;
    logic              trigger, start, rd_issue, seq_int;
    logic [RD_LAT-1:0] vld_sr, first_sr, last_sr;

    assign trigger  = wrt_smpl && ((cnt + 1'b1) >= TAPS_X);
    assign seq_int  = (state == BURST) || (state == DRAIN);
    assign start    = !seq_int && (trigger || pending);
    assign rd_issue = (state == BURST);

    // A pending burst windows on the latest write, which may be this cycle's
    assign w_sel  = wrt_smpl ? new_ptr : last_w;
    assign w_ext  = {1'b0, w_sel};
    assign oldest = (w_ext >= SPAN) ? AW'(w_ext - SPAN) : AW'(w_ext + DEPTH_X - SPAN);

    circ_ptr #(.AW(AW), .DEPTH(DEPTH)) u_new_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (wrt_smpl),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (new_ptr)
    );

    circ_ptr #(.AW(AW), .DEPTH(DEPTH)) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (rd_issue),
        .load     (start),
        .load_val (oldest),
        .ptr      (rd_ptr)
    );

    always_comb begin
        state_nx = state;
        case (state)
            FILL, IDLE: if (start) state_nx = BURST;
            BURST:      if (beat == LAST_RD) state_nx = DRAIN;
            DRAIN:      if (beat == LAST_DR) state_nx = IDLE;
            default:    state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            cnt      <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            full     <= 1'b0;
            beat     <= '0;
            last_w   <= '0;
            vld_sr   <= '0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            state <= state_nx;
            if (wrt_smpl) begin
                last_w <= new_ptr;
                if (cnt != TAPS_X)
                    cnt <= cnt + 1'b1;
            end
            full <= (cnt == TAPS_X) || (wrt_smpl && ((cnt + 1'b1) == TAPS_X));

            // Triggers arriving mid-burst coalesce into one follow-up burst
            if (seq_int && trigger) begin
                pending <= 1'b1;
                if (pending)
                    overrun <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end

            if (!seq_int || (state_nx != state))
                beat <= '0;
            else
                beat <= beat + 1'b1;

            vld_sr[0]   <= rd_issue;
            first_sr[0] <= rd_issue && (beat == '0);
            last_sr[0]  <= rd_issue && (beat == LAST_RD);
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                first_sr[i] <= first_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign we         = wrt_smpl & ~rst;
    assign waddr      = new_ptr;
    assign raddr      = rd_ptr;
    assign rd_en      = rd_issue & ~rst;
    assign smpl_vld   = vld_sr[RD_LAT-1] & ~rst;
    assign first_smpl = first_sr[RD_LAT-1] & ~rst;
    assign last_smpl  = last_sr[RD_LAT-1] & ~rst;
    assign sequencing = seq_int & ~rst;

endmodule

// File: tb/tb_hif_queue_sequencer.sv
// Bench for hif_queue_sequencer: RD_LAT=1 and RD_LAT=2 instances share stimulus
// and are scored each cycle against a burst-schedule model.
module tb_hif_queue_sequencer;

    localparam int DEPTH = 1536;
    localparam int TAPS  = 1021;
    localparam int AW    = 11;

    logic clk = 1'b0;
    logic rst, wrt_smpl;
    logic we_o[2], rd_en_o[2], vld_o[2], first_o[2], last_o[2], seq_o[2], full_o[2], ovr_o[2];
    logic [AW-1:0] waddr_o[2], raddr_o[2];

    always #5 clk = ~clk;

    hif_queue_sequencer #(.DEPTH(DEPTH), .AW(AW), .TAPS(TAPS), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .we(we_o[0]), .waddr(waddr_o[0]),
        .raddr(raddr_o[0]), .rd_en(rd_en_o[0]), .smpl_vld(vld_o[0]), .first_smpl(first_o[0]),
        .last_smpl(last_o[0]), .sequencing(seq_o[0]), .full(full_o[0]), .overrun(ovr_o[0]));

    hif_queue_sequencer #(.DEPTH(DEPTH), .AW(AW), .TAPS(TAPS), .RD_LAT(2)) dut_lat2 (
        .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .we(we_o[1]), .waddr(waddr_o[1]),
        .raddr(raddr_o[1]), .rd_en(rd_en_o[1]), .smpl_vld(vld_o[1]), .first_smpl(first_o[1]),
        .last_smpl(last_o[1]), .sequencing(seq_o[1]), .full(full_o[1]), .overrun(ovr_o[1]));

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;

    // Model: write side is shared, burst schedule is per read latency (k -> RD_LAT=k+1)
    int     m_wp, m_cnt, m_last_w;
    bit     m_full;
    longint m_bs[2];
    int     m_base[2];
    bit     m_pend[2], m_ovr[2];

    function automatic bit busy(int k);
        return m_bs[k] >= 0 && cyc < m_bs[k] + TAPS + k + 1;
    endfunction

    task automatic step(input bit w, input bit r);
        bit        seq_now[2];
        bit        trig;
        logic [7:0] obs, expv, mask;
        longint    bs;
        int        lat, ra;
        @(negedge clk);
        wrt_smpl = w;
        rst      = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            lat = k + 1;
            bs  = m_bs[k];
            seq_now[k] = bs >= 0 && cyc >= bs && cyc < bs + TAPS + lat;
            expv[7] = w && !r;
            expv[6] = !r && bs >= 0 && cyc >= bs && cyc < bs + TAPS;
            expv[5] = !r && bs >= 0 && cyc >= bs + lat && cyc < bs + TAPS + lat;
            expv[4] = !r && bs >= 0 && cyc == bs + lat;
            expv[3] = !r && bs >= 0 && cyc == bs + TAPS - 1 + lat;
            expv[2] = !r && seq_now[k];
            expv[1] = m_full;
            expv[0] = m_ovr[k];
            mask = r ? 8'hFC : 8'hFF;
            obs = {we_o[k], rd_en_o[k], vld_o[k], first_o[k], last_o[k], seq_o[k], full_o[k], ovr_o[k]};
            n_vec++;
            if ((obs & mask) !== (expv & mask)) begin
                n_err++;
                $display("FAIL flags lat%0d cyc %0d: got %b want %b (we,rd_en,vld,first,last,seq,full,ovr)",
                         lat, cyc, obs & mask, expv & mask);
            end
            if (!r) begin
                n_vec++;
                if (waddr_o[k] !== AW'(m_wp)) begin
                    n_err++;
                    $display("FAIL waddr lat%0d cyc %0d: got %0d want %0d", lat, cyc, waddr_o[k], m_wp);
                end
            end
            if (expv[6]) begin
                ra = int'((longint'(m_base[k]) + (cyc - bs)) % DEPTH);
                n_vec++;
                if (raddr_o[k] !== AW'(ra)) begin
                    n_err++;
                    $display("FAIL raddr lat%0d cyc %0d: got %0d want %0d", lat, cyc, raddr_o[k], ra);
                end
            end
        end
        if (r) begin
            m_wp = 0; m_cnt = 0; m_last_w = 0; m_full = 0;
            for (int k = 0; k < 2; k++) begin
                m_bs[k] = -1; m_base[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
            end
        end else begin
            trig = w && (m_cnt + 1 >= TAPS);
            if (w) begin
                m_last_w = m_wp;
                m_wp = (m_wp + 1) % DEPTH;
                if (m_cnt < TAPS) m_cnt++;
            end
            m_full = (m_cnt == TAPS);
            for (int k = 0; k < 2; k++) begin
                if (seq_now[k]) begin
                    if (trig) begin
                        if (m_pend[k]) m_ovr[k] = 1;
                        m_pend[k] = 1;
                    end
                end else if (trig || m_pend[k]) begin
                    m_bs[k]   = cyc + 1;
                    m_base[k] = (m_last_w + DEPTH - (TAPS - 1)) % DEPTH;
                    m_pend[k] = 0;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic wait_quiet();
        int g = 0;
        while (g < 4000 && (m_pend[0] || m_pend[1] || busy(0) || busy(1))) begin
            step(0, 0);
            g++;
        end
        n_vec++;
        if (g >= 4000) begin
            n_err++;
            $display("FAIL quiet_timeout: waited %0d cycles, limit 4000", g);
        end
    endtask

    task automatic wait_seq_low();
        int g = 0;
        while (seq_o[0] !== 1'b0 && g < 3000) begin
            step(0, 0);
            g++;
        end
        n_vec++;
        if (g >= 3000) begin
            n_err++;
            $display("FAIL seq_timeout: sequencing still %b after %0d cycles", seq_o[0], g);
        end
    endtask

    task automatic test_reset();
        step(0, 1);
        step(0, 1);
        step(0, 0);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({we_o[k], rd_en_o[k], vld_o[k], first_o[k], last_o[k], seq_o[k], full_o[k], ovr_o[k]} !== 8'h00
                || waddr_o[k] !== '0 || raddr_o[k] !== '0) begin
                n_err++;
                $display("FAIL reset_state lat%0d: flags %b waddr %0d raddr %0d, want all 0",
                         k + 1, {we_o[k], rd_en_o[k], vld_o[k], first_o[k], last_o[k], seq_o[k],
                                 full_o[k], ovr_o[k]}, waddr_o[k], raddr_o[k]);
            end
        end
    endtask

    task automatic test_fill();
        bit     saw_rd = 0;
        longint t;
        step(0, 1);
        for (int i = 0; i < TAPS - 1; i++) begin
            step(1, 0);
            if (rd_en_o[0] || rd_en_o[1]) saw_rd = 1;
        end
        n_vec++;
        if (saw_rd !== 1'b0 || full_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL fill_quiet: rd_en seen %b full %b, want 0 0", saw_rd, full_o[0]);
        end
        step(1, 0);
        t = cyc - 1;
        n_vec++;
        if (waddr_o[0] !== AW'(TAPS - 1)) begin
            n_err++;
            $display("FAIL fill_waddr: got %0d want %0d", waddr_o[0], TAPS - 1);
        end
        step(0, 0);
        n_vec++;
        if (rd_en_o[0] !== 1'b1 || raddr_o[0] !== '0) begin
            n_err++;
            $display("FAIL fill_first_read: rd_en %b raddr %0d, want 1 0", rd_en_o[0], raddr_o[0]);
        end
        while (cyc - 1 < t + TAPS) step(0, 0);
        n_vec++;
        if (rd_en_o[0] !== 1'b1 || raddr_o[0] !== AW'(TAPS - 1)) begin
            n_err++;
            $display("FAIL fill_final_read: rd_en %b raddr %0d, want 1 %0d", rd_en_o[0], raddr_o[0], TAPS - 1);
        end
        step(0, 0);
        n_vec++;
        if (last_o[0] !== 1'b1 || rd_en_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL fill_last: last %b rd_en %b, want 1 0", last_o[0], rd_en_o[0]);
        end
        step(0, 0);
        n_vec++;
        if (seq_o[0] !== 1'b0 || seq_o[1] !== 1'b1 || last_o[1] !== 1'b1) begin
            n_err++;
            $display("FAIL lat2_tail: seq1 %b seq2 %b last2 %b, want 0 1 1", seq_o[0], seq_o[1], last_o[1]);
        end
        step(0, 0);
        n_vec++;
        if (seq_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL lat2_seq_end: seq2 %b want 0", seq_o[1]);
        end
        wait_quiet();
    endtask

    task automatic test_wrap();
        int g, nv, first_ra, prev, last_ra, want_first;
        bit wrapped;
        step(0, 1);
        for (int i = 0; i < 1600; i++) step(1, 0);
        wait_seq_low();
        g = 0;
        while (rd_en_o[0] !== 1'b1 && g < 3000) begin
            step(0, 0);
            g++;
        end
        want_first = (1599 % DEPTH) + DEPTH - (TAPS - 1);
        first_ra = int'(raddr_o[0]);
        n_vec++;
        if (first_ra != want_first) begin
            n_err++;
            $display("FAIL wrap_first: raddr %0d want %0d", first_ra, want_first);
        end
        nv = 0; wrapped = 0; prev = first_ra; last_ra = first_ra; g = 0;
        while (seq_o[0] === 1'b1 && g < 3000) begin
            step(0, 0);
            g++;
            if (vld_o[0]) nv++;
            if (rd_en_o[0]) begin
                if (prev == DEPTH - 1 && raddr_o[0] == 0) wrapped = 1;
                prev = int'(raddr_o[0]);
                last_ra = prev;
            end
        end
        n_vec++;
        if (nv != TAPS || !wrapped || last_ra != 1599 % DEPTH) begin
            n_err++;
            $display("FAIL wrap_burst: vld %0d wrapped %b last %0d, want %0d 1 %0d",
                     nv, wrapped, last_ra, TAPS, 1599 % DEPTH);
        end
        wait_quiet();
    endtask

    task automatic test_mid_burst();
        longint t;
        int     base1;
        step(0, 1);
        for (int i = 0; i < TAPS; i++) step(1, 0);
        t = cyc - 1;
        step(0, 0);
        base1 = int'(raddr_o[0]);
        while (cyc - 1 < t + 499) step(0, 0);
        step(1, 0);
        n_vec++;
        if (we_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_we: we %b want 1", we_o[0]);
        end
        wait_seq_low();
        step(0, 0);
        n_vec++;
        if (rd_en_o[0] !== 1'b1 || raddr_o[0] !== AW'((base1 + 1) % DEPTH)) begin
            n_err++;
            $display("FAIL mid_next_burst: rd_en %b raddr %0d, want 1 %0d", rd_en_o[0], raddr_o[0],
                     (base1 + 1) % DEPTH);
        end
        n_vec++;
        if (ovr_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_overrun: got %b want 0", ovr_o[0]);
        end
        wait_quiet();
    endtask

    task automatic test_double_trigger();
        int nb = 0;
        step(1, 0);
        idle(100);
        step(1, 0);
        idle(100);
        step(1, 0);
        wait_seq_low();
        step(0, 0);
        n_vec++;
        if (rd_en_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL double_extra_burst: rd_en %b want 1", rd_en_o[0]);
        end
        wait_seq_low();
        for (int i = 0; i < 1100; i++) begin
            step(0, 0);
            if (rd_en_o[0]) nb++;
        end
        n_vec++;
        if (nb != 0 || ovr_o[0] !== 1'b1 || ovr_o[1] !== 1'b1) begin
            n_err++;
            $display("FAIL double_coalesce: later reads %0d ovr %b%b, want 0 11", nb, ovr_o[0], ovr_o[1]);
        end
        step(0, 1);
        step(0, 0);
        n_vec++;
        if (ovr_o[0] !== 1'b0 || ovr_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: ovr %b%b want 00", ovr_o[0], ovr_o[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        longint t;
        bit     saw_rd = 0;
        for (int i = 0; i < TAPS; i++) step(1, 0);
        t = cyc - 1;
        while (cyc - 1 < t + 299) step(0, 0);
        step(0, 1);
        step(0, 0);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({we_o[k], rd_en_o[k], vld_o[k], first_o[k], last_o[k], seq_o[k], full_o[k], ovr_o[k]} !== 8'h00
                || waddr_o[k] !== '0 || raddr_o[k] !== '0) begin
                n_err++;
                $display("FAIL abort_state lat%0d: flags %b waddr %0d raddr %0d, want all 0",
                         k + 1, {we_o[k], rd_en_o[k], vld_o[k], first_o[k], last_o[k], seq_o[k],
                                 full_o[k], ovr_o[k]}, waddr_o[k], raddr_o[k]);
            end
        end
        for (int i = 0; i < TAPS; i++) begin
            step(1, 0);
            if (rd_en_o[0] || rd_en_o[1]) saw_rd = 1;
        end
        step(0, 0);
        n_vec++;
        if (saw_rd !== 1'b0 || rd_en_o[0] !== 1'b1 || raddr_o[0] !== '0) begin
            n_err++;
            $display("FAIL refill: early rd %b, rd_en %b raddr %0d, want 0 1 0", saw_rd, rd_en_o[0], raddr_o[0]);
        end
        wait_quiet();
    endtask

    task automatic test_random();
        int th = 0;
        bit w, r;
        step(0, 1);
        for (int i = 0; i < 16000; i++) begin
            if (i % 2000 == 0) begin
                case ($urandom_range(0, 3))
                    0:       th = 1;
                    1:       th = 3;
                    2:       th = 30;
                    default: th = 600;
                endcase
            end
            w = ($urandom_range(0, 999) < th);
            r = ($urandom_range(0, 3999) == 0);
            step(w, r);
        end
        wait_quiet();
    endtask

    initial begin
        rst      = 1'b1;
        wrt_smpl = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_mid_burst();
        test_double_trigger();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
